// File: rtl/fi_bi_pkg.sv
// Shared definitions for the FI/BI block path: width defaults, descriptor packing
// {FDSSI, SSI, STI, CNT} (MSB to LSB) and the read sequencer state encoding.
package fi_bi_pkg;

    localparam int unsigned DEF_LANES_LOG2      = 2;
    localparam int unsigned DEF_FDSSI_WIDTH     = 12;
    localparam int unsigned DEF_SSI_WIDTH       = 8;
    localparam int unsigned DEF_STI_WIDTH       = 8;
    localparam int unsigned DEF_CNT_WIDTH       = 8;
    localparam int unsigned DEF_LANE_ADDR_WIDTH = 12;
    localparam int unsigned DEF_INFO_WIDTH      =
        DEF_FDSSI_WIDTH + DEF_SSI_WIDTH + DEF_STI_WIDTH + DEF_CNT_WIDTH;

    localparam int unsigned CNT_LSB   = 0;
    localparam int unsigned STI_LSB   = CNT_LSB + DEF_CNT_WIDTH;
    localparam int unsigned SSI_LSB   = STI_LSB + DEF_STI_WIDTH;
    localparam int unsigned FDSSI_LSB = SSI_LSB + DEF_SSI_WIDTH;

    typedef logic [DEF_INFO_WIDTH-1:0] info_t;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } seq_state_e;

    function automatic logic [DEF_FDSSI_WIDTH-1:0] info_fdssi(input info_t info);
        return info[FDSSI_LSB +: DEF_FDSSI_WIDTH];
    endfunction

    function automatic logic [DEF_SSI_WIDTH-1:0] info_ssi(input info_t info);
        return info[SSI_LSB +: DEF_SSI_WIDTH];
    endfunction

    function automatic logic [DEF_STI_WIDTH-1:0] info_sti(input info_t info);
        return info[STI_LSB +: DEF_STI_WIDTH];
    endfunction

    function automatic logic [DEF_CNT_WIDTH-1:0] info_cnt(input info_t info);
        return info[CNT_LSB +: DEF_CNT_WIDTH];
    endfunction

    // A zero count is the wrapped encoding of a full 2**CNT_WIDTH beat block.
    function automatic logic [DEF_CNT_WIDTH:0] info_beats(input info_t info);
        logic [DEF_CNT_WIDTH-1:0] cnt;
        cnt = info_cnt(info);
        return (cnt == '0) ? {1'b1, cnt} : {1'b0, cnt};
    endfunction

endpackage

// File: rtl/fi_bi_block_read_sequencer_if.sv
// Descriptor-in / read-command-out bundle of the block read sequencer.
// master: the sequencer side; slave: descriptor FIFOs plus data buffer side.
interface fi_bi_block_read_sequencer_if #(
    parameter int unsigned LANES_LOG2      = fi_bi_pkg::DEF_LANES_LOG2,
    parameter int unsigned FDSSI_WIDTH     = fi_bi_pkg::DEF_FDSSI_WIDTH,
    parameter int unsigned SSI_WIDTH       = fi_bi_pkg::DEF_SSI_WIDTH,
    parameter int unsigned STI_WIDTH       = fi_bi_pkg::DEF_STI_WIDTH,
    parameter int unsigned CNT_WIDTH       = fi_bi_pkg::DEF_CNT_WIDTH,
    parameter int unsigned INFO_WIDTH      = fi_bi_pkg::DEF_INFO_WIDTH,
    parameter int unsigned LANE_ADDR_WIDTH = fi_bi_pkg::DEF_LANE_ADDR_WIDTH
) ();

    localparam int unsigned LANES = 2 ** LANES_LOG2;

    logic [LANES-1:0]                       s_info_tvalid;
    logic [LANES-1:0]                       s_info_tready;
    logic [LANES*INFO_WIDTH-1:0]            s_info;

    logic                                   m_rd_valid;
    logic                                   m_rd_ready;
    logic [LANES_LOG2+LANE_ADDR_WIDTH-1:0]  m_rd_addr;
    logic                                   m_rd_last;
    logic [LANES_LOG2-1:0]                  m_rd_lane;
    logic [FDSSI_WIDTH-1:0]                 m_rd_fdssi;
    logic [SSI_WIDTH-1:0]                   m_rd_ssi;
    logic [STI_WIDTH-1:0]                   m_rd_sti;
    logic [CNT_WIDTH-1:0]                   m_rd_beat;
    logic                                   busy;

    modport master (
        input  s_info_tvalid, s_info, m_rd_ready,
        output s_info_tready, m_rd_valid, m_rd_addr, m_rd_last, m_rd_lane,
        output m_rd_fdssi, m_rd_ssi, m_rd_sti, m_rd_beat, busy
    );

    modport slave (
        output s_info_tvalid, s_info, m_rd_ready,
        input  s_info_tready, m_rd_valid, m_rd_addr, m_rd_last, m_rd_lane,
        input  m_rd_fdssi, m_rd_ssi, m_rd_sti, m_rd_beat, busy
    );

endinterface

// File: rtl/fi_bi_rr_arbiter.sv
// Combinational round-robin arbiter: first requesting lane at or above rr_ptr,
// wrapping, reported as a one-hot grant and an encoded index.
module fi_bi_rr_arbiter #(
    parameter int unsigned LANES_LOG2 = fi_bi_pkg::DEF_LANES_LOG2
) (
    input  logic [2**LANES_LOG2-1:0] req,
    input  logic [LANES_LOG2-1:0]    rr_ptr,
    output logic [2**LANES_LOG2-1:0] grant,
    output logic [LANES_LOG2-1:0]    grant_idx,
    output logic                     grant_valid
);

    localparam int unsigned LANES = 2 ** LANES_LOG2;

    logic [LANES_LOG2-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned off = 0; off < LANES; off++) begin
            cand = rr_ptr + LANES_LOG2'(off);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fi_bi_block_read_sequencer.sv
// Pops one block descriptor at a time from the per-lane FIFOs and expands it into a
// beat-by-beat read command stream, tracking each lane's read pointer in the buffer.
module fi_bi_block_read_sequencer
    import fi_bi_pkg::*;
#(
    parameter int unsigned LANES_LOG2      = DEF_LANES_LOG2,
    parameter int unsigned FDSSI_WIDTH     = DEF_FDSSI_WIDTH,
    parameter int unsigned SSI_WIDTH       = DEF_SSI_WIDTH,
    parameter int unsigned STI_WIDTH       = DEF_STI_WIDTH,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int unsigned INFO_WIDTH      = DEF_INFO_WIDTH,
    parameter int unsigned LANE_ADDR_WIDTH = DEF_LANE_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    fi_bi_block_read_sequencer_if.master bus
);

    localparam int unsigned LANES      = 2 ** LANES_LOG2;
    localparam int unsigned ADDR_WIDTH = LANES_LOG2 + LANE_ADDR_WIDTH;

    typedef logic [LANE_ADDR_WIDTH-1:0] ptr_t;

    seq_state_e              state_q, state_d;
    logic [LANES_LOG2-1:0]   rr_ptr_q, rr_ptr_d;
    ptr_t                    ptr_q [LANES];
    ptr_t                    ptr_d [LANES];
    logic [LANES_LOG2-1:0]   lane_q, lane_d;
    logic [FDSSI_WIDTH-1:0]  fdssi_q, fdssi_d;
    logic [SSI_WIDTH-1:0]    ssi_q, ssi_d;
    logic [STI_WIDTH-1:0]    sti_q, sti_d;
    logic [CNT_WIDTH-1:0]    beat_q, beat_d;
    logic [CNT_WIDTH:0]      beats_left_q, beats_left_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    last_q, last_d;

    logic [LANES-1:0]        grant;
    logic [LANES_LOG2-1:0]   grant_idx;
    logic                    grant_valid;
    logic [LANES-1:0]        tready;
    logic [INFO_WIDTH-1:0]   sel_info;
    logic [CNT_WIDTH:0]      sel_beats;
    ptr_t                    ptr_next;

    fi_bi_rr_arbiter #(
        .LANES_LOG2(LANES_LOG2)
    ) u_arb (
        .req        (bus.s_info_tvalid),
        .rr_ptr     (rr_ptr_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    assign sel_info  = bus.s_info[grant_idx*INFO_WIDTH +: INFO_WIDTH];
    assign sel_beats = info_beats(sel_info);
    assign ptr_next  = ptr_q[lane_q] + 1'b1;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        ptr_d        = ptr_q;
        lane_d       = lane_q;
        fdssi_d      = fdssi_q;
        ssi_d        = ssi_q;
        sti_d        = sti_q;
        beat_d       = beat_q;
        beats_left_d = beats_left_q;
        addr_d       = addr_q;
        last_d       = last_q;
        tready       = '0;

        unique case (state_q)
            StIdle: begin
                // The grant only exists for a valid lane, so tready here is the handshake.
                tready = grant;
                if (grant_valid) begin
                    lane_d       = grant_idx;
                    fdssi_d      = info_fdssi(sel_info);
                    ssi_d        = info_ssi(sel_info);
                    sti_d        = info_sti(sel_info);
                    beats_left_d = sel_beats;
                    beat_d       = '0;
                    addr_d       = {grant_idx, ptr_q[grant_idx]};
                    last_d       = (sel_beats == (CNT_WIDTH+1)'(1));
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (bus.m_rd_ready) begin
                    ptr_d[lane_q] = ptr_next;
                    beat_d        = beat_q + 1'b1;
                    beats_left_d  = beats_left_q - 1'b1;
                    addr_d        = {lane_q, ptr_next};
                    last_d        = (beats_left_q == (CNT_WIDTH+1)'(2));
                    if (last_q) begin
                        rr_ptr_d = lane_q + 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            for (int i = 0; i < LANES; i++) begin
                ptr_q[i] <= '0;
            end
            lane_q       <= '0;
            fdssi_q      <= '0;
            ssi_q        <= '0;
            sti_q        <= '0;
            beat_q       <= '0;
            beats_left_q <= '0;
            addr_q       <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            ptr_q        <= ptr_d;
            lane_q       <= lane_d;
            fdssi_q      <= fdssi_d;
            ssi_q        <= ssi_d;
            sti_q        <= sti_d;
            beat_q       <= beat_d;
            beats_left_q <= beats_left_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
        end
    end

    assign bus.s_info_tready = tready;
    assign bus.m_rd_valid    = (state_q == StIssue);
    assign bus.busy          = (state_q == StIssue);
    assign bus.m_rd_addr     = addr_q;
    assign bus.m_rd_last     = last_q;
    assign bus.m_rd_lane     = lane_q;
    assign bus.m_rd_fdssi    = fdssi_q;
    assign bus.m_rd_ssi      = ssi_q;
    assign bus.m_rd_sti      = sti_q;
    assign bus.m_rd_beat     = beat_q;

endmodule

// File: tb/tb_fi_bi_block_read_sequencer.sv
// Self-checking bench: a descriptor table plus hand-written corner sequences, with every
// expected read beat queued on a scoreboard and checked as the DUT issues it.
module tb_fi_bi_block_read_sequencer;
    import fi_bi_pkg::*;

    localparam int unsigned LANES = 4;
    localparam int unsigned IW    = DEF_INFO_WIDTH;

    typedef struct {
        logic [13:0] addr;
        logic        last;
        logic [1:0]  lane;
        logic [11:0] fdssi;
        logic [7:0]  ssi;
        logic [7:0]  sti;
        logic [7:0]  beat;
    } beat_t;

    typedef struct {
        int          lane;
        logic [7:0]  cnt;
        logic [11:0] fdssi;
        logic [7:0]  ssi;
        logic [7:0]  sti;
        int          start;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fi_bi_block_read_sequencer_if bus ();

    fi_bi_block_read_sequencer dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    vec_t  vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] mk_info(input logic [11:0] fd, input logic [7:0] ss,
                                              input logic [7:0] st, input logic [7:0] cnt);
        return {fd, ss, st, cnt};
    endfunction

    task automatic push_block(input int lane, input int start, input int n,
                              input logic [11:0] fd, input logic [7:0] ss, input logic [7:0] st);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.addr  = {2'(lane), 12'(start + i)};
            e.last  = (i == n - 1);
            e.lane  = 2'(lane);
            e.fdssi = fd;
            e.ssi   = ss;
            e.sti   = st;
            e.beat  = 8'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.m_rd_valid && bus.m_rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: addr 0x%0h issued, none expected",
                             bus.m_rd_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_addr", 32'(bus.m_rd_addr), 32'(e.addr));
                    chk("rd_last", 32'(bus.m_rd_last), 32'(e.last));
                    chk("rd_lane", 32'(bus.m_rd_lane), 32'(e.lane));
                    chk("rd_fdssi", 32'(bus.m_rd_fdssi), 32'(e.fdssi));
                    chk("rd_ssi", 32'(bus.m_rd_ssi), 32'(e.ssi));
                    chk("rd_sti", 32'(bus.m_rd_sti), 32'(e.sti));
                    chk("rd_beat", 32'(bus.m_rd_beat), 32'(e.beat));
                end
            end
            if (!rst && bus.s_info_tready != '0) begin
                chk("tready_onehot", 32'($onehot(bus.s_info_tready)), 32'd1);
                chk("tready_on_valid", 32'((bus.s_info_tready & ~bus.s_info_tvalid) == '0), 32'd1);
                chk("tready_idle_only", 32'(bus.busy), 32'd0);
            end
        end
    endtask

    // Present descriptors on the lanes in mask; lanes in refill get one more descriptor
    // right after their first acceptance. Returns once every presented descriptor is taken.
    task automatic offer(input logic [3:0] mask, input logic [LANES*IW-1:0] infos,
                         input logic [3:0] refill_mask, input logic [LANES*IW-1:0] refill_infos);
        logic [3:0] hs;
        logic [3:0] refill;
        int         budget;
        refill = refill_mask;
        budget = 1000;
        @(posedge clk);
        #1;
        bus.s_info           = infos;
        bus.s_info_tvalid    = mask;
        while (bus.s_info_tvalid != '0 && budget > 0) begin
            @(negedge clk);
            hs = bus.s_info_tready & bus.s_info_tvalid;
            @(posedge clk);
            #1;
            budget--;
            if (hs != '0) begin
                chk("valid_after_accept", 32'(bus.m_rd_valid), 32'd1);
                bus.s_info_tvalid = bus.s_info_tvalid & ~hs;
                for (int i = 0; i < LANES; i++) begin
                    if (hs[i] && refill[i]) begin
                        bus.s_info[i*IW +: IW] = refill_infos[i*IW +: IW];
                        bus.s_info_tvalid[i]   = 1'b1;
                    end
                end
                refill = refill & ~hs;
            end
        end
        if (budget == 0) begin
            chk("offer_timeout", 32'(bus.s_info_tvalid), 32'd0);
            bus.s_info_tvalid = '0;
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 1000;
        do begin
            @(negedge clk);
            budget--;
        end while ((exp_q.size() != 0 || bus.m_rd_valid) && budget > 0);
        if (budget == 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst               = 1'b1;
        bus.s_info_tvalid = '0;
        bus.m_rd_ready    = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(bus.m_rd_valid), 32'd0);
        rst = 1'b0;
    endtask

    task automatic send_one(input int lane, input logic [7:0] cnt, input logic [11:0] fd,
                            input logic [7:0] ss, input logic [7:0] st, input int start);
        logic [LANES*IW-1:0] infos;
        infos                   = '0;
        infos[lane*IW +: IW]    = mk_info(fd, ss, st, cnt);
        push_block(lane, start, (cnt == 8'd0) ? 256 : int'(cnt), fd, ss, st);
        offer(4'(1 << lane), infos, 4'b0000, '0);
        wait_drain();
    endtask

    initial begin
        logic [LANES*IW-1:0] infos;
        logic [LANES*IW-1:0] refills;
        int                  budget;

        vecs[0] = '{lane: 0, cnt: 8'd3, fdssi: 12'hABC, ssi: 8'h11, sti: 8'h5A, start: 0};
        vecs[1] = '{lane: 1, cnt: 8'd2, fdssi: 12'h123, ssi: 8'h22, sti: 8'h01, start: 0};
        vecs[2] = '{lane: 0, cnt: 8'd1, fdssi: 12'hFFF, ssi: 8'hFF, sti: 8'hFF, start: 3};
        vecs[3] = '{lane: 2, cnt: 8'd5, fdssi: 12'h001, ssi: 8'h80, sti: 8'h7F, start: 0};
        vecs[4] = '{lane: 1, cnt: 8'd1, fdssi: 12'h800, ssi: 8'h01, sti: 8'h80, start: 2};
        vecs[5] = '{lane: 3, cnt: 8'd2, fdssi: 12'h555, ssi: 8'hAA, sti: 8'h33, start: 0};
        vecs[6] = '{lane: 0, cnt: 8'd2, fdssi: 12'h0F0, ssi: 8'h0F, sti: 8'hC3, start: 4};

        fork
            monitor();
        join_none

        rst               = 1'b1;
        bus.s_info_tvalid = '0;
        bus.s_info        = '0;
        bus.m_rd_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 32'(bus.s_info_tready), 32'd0);
        chk("rst_valid", 32'(bus.m_rd_valid), 32'd0);
        chk("rst_last", 32'(bus.m_rd_last), 32'd0);
        chk("rst_addr", 32'(bus.m_rd_addr), 32'd0);
        chk("rst_lane", 32'(bus.m_rd_lane), 32'd0);
        chk("rst_fdssi", 32'(bus.m_rd_fdssi), 32'd0);
        chk("rst_ssi", 32'(bus.m_rd_ssi), 32'd0);
        chk("rst_sti", 32'(bus.m_rd_sti), 32'd0);
        chk("rst_beat", 32'(bus.m_rd_beat), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Single-lane descriptors in sequence; start pointers follow per-lane history.
        foreach (vecs[k]) begin
            send_one(vecs[k].lane, vecs[k].cnt, vecs[k].fdssi, vecs[k].ssi, vecs[k].sti,
                     vecs[k].start);
        end

        // Lanes 0 and 2 together, lane 0 refilled: grant order 0, 2, 0.
        do_reset();
        infos              = '0;
        infos[0*IW +: IW]  = mk_info(12'h010, 8'hA0, 8'h01, 8'd1);
        infos[2*IW +: IW]  = mk_info(12'h020, 8'hA2, 8'h02, 8'd1);
        refills            = '0;
        refills[0*IW +: IW] = mk_info(12'h030, 8'hA4, 8'h03, 8'd1);
        push_block(0, 0, 1, 12'h010, 8'hA0, 8'h01);
        push_block(2, 0, 1, 12'h020, 8'hA2, 8'h02);
        push_block(0, 1, 1, 12'h030, 8'hA4, 8'h03);
        offer(4'b0101, infos, 4'b0001, refills);
        wait_drain();

        // Lane 3 with CNT=0 expands to 256 beats; beat index wraps only after the last.
        do_reset();
        send_one(3, 8'd0, 12'h333, 8'h33, 8'h33, 0);
        chk("beat_wrap_after_block", 32'(bus.m_rd_beat), 32'd0);

        // Advance lane 1 to 4094, then a 4-beat block wraps its pointer.
        do_reset();
        for (int b = 0; b < 15; b++) begin
            send_one(1, 8'd0, 12'h100, 8'h10, 8'h01, b * 256);
        end
        send_one(1, 8'd254, 12'h100, 8'h10, 8'h01, 3840);
        send_one(1, 8'd4, 12'h1AB, 8'h1C, 8'h1D, 4094);
        send_one(0, 8'd1, 12'h0AA, 8'h0B, 8'h0C, 0);

        // Stall ready for 5 cycles mid-block while lane 3 waits.
        push_block(2, 0, 6, 12'h2EE, 8'h2F, 8'h20);
        infos             = '0;
        infos[2*IW +: IW] = mk_info(12'h2EE, 8'h2F, 8'h20, 8'd6);
        offer(4'b0100, infos, 4'b0000, '0);
        bus.s_info[3*IW +: IW] = mk_info(12'h3AA, 8'h3B, 8'h3C, 8'd1);
        bus.s_info_tvalid      = 4'b1000;
        push_block(3, 0, 1, 12'h3AA, 8'h3B, 8'h3C);
        budget = 50;
        do begin
            @(negedge clk);
            budget--;
        end while (!(bus.m_rd_valid && bus.m_rd_beat == 8'd1) && budget > 0);
        chk("stall_reach_beat1", 32'(bus.m_rd_beat), 32'd1);
        @(posedge clk);
        #1;
        bus.m_rd_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.m_rd_valid), 32'd1);
            chk("stall_addr", 32'(bus.m_rd_addr), 32'h2002);
            chk("stall_beat", 32'(bus.m_rd_beat), 32'd2);
            chk("stall_last", 32'(bus.m_rd_last), 32'd0);
            chk("stall_ssi", 32'(bus.m_rd_ssi), 32'h2F);
            chk("stall_tready", 32'(bus.s_info_tready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.m_rd_ready = 1'b1;
        budget = 50;
        do begin
            @(negedge clk);
            budget--;
        end while (!bus.s_info_tready[3] && budget > 0);
        chk("stall_lane3_granted", 32'(bus.s_info_tready), 32'h8);
        @(posedge clk);
        #1;
        bus.s_info_tvalid = '0;
        wait_drain();

        // Reset in the middle of a lane 2 block, then lane 0 priority and zero pointers.
        send_one(1, 8'd1, 12'h111, 8'h11, 8'h11, 2);
        push_block(2, 6, 6, 12'h222, 8'h22, 8'h22);
        infos             = '0;
        infos[2*IW +: IW] = mk_info(12'h222, 8'h22, 8'h22, 8'd6);
        offer(4'b0100, infos, 4'b0000, '0);
        budget = 50;
        do begin
            @(negedge clk);
            budget--;
        end while (!(bus.m_rd_valid && bus.m_rd_beat == 8'd2) && budget > 0);
        chk("rst_mid_reach_beat2", 32'(bus.m_rd_addr), 32'h2008);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(bus.m_rd_valid), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_addr", 32'(bus.m_rd_addr), 32'd0);
        chk("rst_mid_beat", 32'(bus.m_rd_beat), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        infos             = '0;
        infos[0*IW +: IW] = mk_info(12'h0DD, 8'h0E, 8'h0F, 8'd1);
        infos[2*IW +: IW] = mk_info(12'h2DD, 8'h2E, 8'h2F, 8'd2);
        push_block(0, 0, 1, 12'h0DD, 8'h0E, 8'h0F);
        push_block(2, 0, 2, 12'h2DD, 8'h2E, 8'h2F);
        offer(4'b0101, infos, 4'b0000, '0);
        wait_drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
